// File: rtl/core_run_ctrl.sv
// Run/debug sequencer for the single-cycle MIPS core: host-driven imem load, run/halt/step,
// one breakpoint and halt-instruction detection. Define WATCHDOG_EN to add a RUN-cycle watchdog.
module core_run_ctrl #(
  parameter int          AW         = 8,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h0000000C
`ifdef WATCHDOG_EN
  , parameter int        WDT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_instr,
  output logic             core_reset,
  output logic             core_clk_en,
  output logic             imem_we,
  output logic [AW-1:0]    imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [2:0]       state,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD_BEGIN = 3'd1;
  localparam logic [2:0] OP_LOAD_WORD  = 3'd2;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_STEP       = 3'd4;
  localparam logic [2:0] OP_HALT       = 3'd5;
  localparam logic [2:0] OP_SET_BP     = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_USER  = 3'd1;
  localparam logic [2:0] CAUSE_INSTR = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_WDT   = 3'd4;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             imem_we_q, imem_we_d;
  logic [AW-1:0]    imem_addr_q, imem_addr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             core_reset_q, core_reset_d;
  logic [2:0]       halt_cause_q, halt_cause_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             cmd_err_q, cmd_err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             bp_valid_q, bp_valid_d;
  logic [31:0]      bp_addr_q, bp_addr_d;
  logic             bp_skip_q, bp_skip_d;

  logic       in_run;
  logic       instr_stop;
  logic       bp_stop;
  logic       stop;
  logic       wdt_hit;
  logic       accept;
  logic [2:0] stop_cause;

  always_comb begin
    in_run      = (state_q == ST_RUN);
    instr_stop  = (core_instr == HALT_INSTR);
    // bp_skip lets a resume from HALT execute the instruction sitting on the breakpoint.
    bp_stop     = bp_valid_q && (core_pc == bp_addr_q) && !bp_skip_q;
    stop        = in_run && (instr_stop || bp_stop);
    stop_cause  = instr_stop ? CAUSE_INSTR : CAUSE_BP;
    core_clk_en = (in_run && !stop && !wdt_hit) || (state_q == ST_STEP);
    accept      = cmd_valid && cmd_ready_q;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    core_reset_d  = core_reset_q;
    halt_cause_d  = halt_cause_q;
    cycle_count_d = cycle_count_q;
    cmd_err_d     = 1'b0;
    bp_valid_d    = bp_valid_q;
    bp_addr_d     = bp_addr_q;
    bp_skip_d     = 1'b0;

    if (core_clk_en && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    if (state_q == ST_STEP) begin
      state_d = ST_HALT;
    end

    if (stop) begin
      state_d      = ST_HALT;
      halt_cause_d = stop_cause;
    end else if (wdt_hit) begin
      state_d      = ST_HALT;
      halt_cause_d = CAUSE_WDT;
    end

    if (accept) begin
      case (cmd_op)
        OP_NOP: begin
        end
        OP_LOAD_BEGIN: begin
          if (state_q inside {ST_IDLE, ST_LOAD, ST_HALT}) begin
            ptr_d        = cmd_data[AW+1:2];
            state_d      = ST_LOAD;
            core_reset_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_LOAD_WORD: begin
          if (state_q == ST_LOAD) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ptr_q;
            imem_wdata_d = cmd_data;
            ptr_d        = ptr_q + AW'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RUN: begin
          if (state_q inside {ST_IDLE, ST_LOAD}) begin
            core_reset_d  = 1'b0;
            cycle_count_d = '0;
            halt_cause_d  = CAUSE_NONE;
            state_d       = ST_RUN;
          end else if (state_q == ST_HALT) begin
            halt_cause_d = CAUSE_NONE;
            state_d      = ST_RUN;
            bp_skip_d    = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_STEP: begin
          if (state_q == ST_HALT) begin
            state_d = ST_STEP;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_HALT: begin
          if (!in_run) begin
            cmd_err_d = 1'b1;
          end else if (!stop && !wdt_hit) begin
            state_d      = ST_HALT;
            halt_cause_d = CAUSE_USER;
          end
        end
        OP_SET_BP: begin
          if (cmd_data == 32'hFFFF_FFFF) begin
            bp_valid_d = 1'b0;
          end else begin
            bp_addr_d  = cmd_data;
            bp_valid_d = 1'b1;
          end
        end
        OP_RESET_CORE: begin
          state_d       = ST_IDLE;
          core_reset_d  = 1'b1;
          cycle_count_d = '0;
          halt_cause_d  = CAUSE_NONE;
        end
      endcase
    end

    cmd_ready_d = (state_d != ST_STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      core_reset_q  <= 1'b1;
      halt_cause_q  <= CAUSE_NONE;
      cycle_count_q <= '0;
      cmd_err_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      bp_valid_q    <= 1'b0;
      bp_addr_q     <= '0;
      bp_skip_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_reset_q  <= core_reset_d;
      halt_cause_q  <= halt_cause_d;
      cycle_count_q <= cycle_count_d;
      cmd_err_q     <= cmd_err_d;
      cmd_ready_q   <= cmd_ready_d;
      bp_valid_q    <= bp_valid_d;
      bp_addr_q     <= bp_addr_d;
      bp_skip_q     <= bp_skip_d;
    end
  end

`ifdef WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_hit = in_run && (wdt_q == WDT_W'(WDT_CYCLES));
  end

  // Cleared on every entry to RUN, including a resume from HALT.
  always_comb begin
    wdt_d = wdt_q;
    if (in_run && core_clk_en) begin
      wdt_d = wdt_q + WDT_W'(1);
    end
    if ((state_d == ST_RUN) && !in_run) begin
      wdt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  always_comb begin
    wdt_hit = 1'b0;
  end
`endif

  assign cmd_ready   = cmd_ready_q;
  assign core_reset  = core_reset_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign state       = state_q;
  assign halt_cause  = halt_cause_q;
  assign cycle_count = cycle_count_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a tiny behavioural core (PC + imem) around it.
// Define WATCHDOG_EN to also exercise the watchdog with WDT_CYCLES=16.
module tb_core_run_ctrl;

  localparam logic [2:0] OP_LOAD_BEGIN = 3'd1;
  localparam logic [2:0] OP_LOAD_WORD  = 3'd2;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_STEP       = 3'd4;
  localparam logic [2:0] OP_HALT       = 3'd5;
  localparam logic [2:0] OP_SET_BP     = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;
  localparam logic [31:0] LOOP_INSTR   = 32'h1000FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'h0;
  logic [31:0] core_pc;
  logic [31:0] core_instr;
  logic        core_reset;
  logic        core_clk_en;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  state;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_count;
  logic        cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  core_run_ctrl #(
    .AW(8)
`ifdef WATCHDOG_EN
    , .WDT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .core_pc(core_pc), .core_instr(core_instr),
    .core_reset(core_reset), .core_clk_en(core_clk_en), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .state(state),
    .halt_cause(halt_cause), .cycle_count(cycle_count), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural core: PC advances by 4 per enabled cycle; LOOP_INSTR branches to itself.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [31:0] pc_m = 32'h0;
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (core_reset) pc_m <= 32'h0;
    else if (core_clk_en) pc_m <= (mem[pc_m[9:2]] == LOOP_INSTR) ? pc_m : pc_m + 32'd4;
  end
  assign core_pc    = pc_m;
  assign core_instr = mem[pc_m[9:2]];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    $display("cmd op=%0d data=%h -> state=%0d cause=%0d cnt=%0d err=%0b", op, data, state, halt_cause, cycle_count, cmd_err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #20;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset got %b exp 1", core_reset); end
    n_checks++; if (core_clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en got %b exp 0", core_clk_en); end
    n_checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_imem got we=%b a=%0d d=%h exp 0/0/0", imem_we, imem_addr, imem_wdata); end
    n_checks++; if (halt_cause !== 3'd0 || cycle_count !== 32'd0 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_status got cause=%0d cnt=%0d err=%b exp 0/0/0", halt_cause, cycle_count, cmd_err); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", cmd_ready); end
    reset = 1'b1;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load();
    logic [31:0] words [0:2];
    words[0] = 32'h20080005; words[1] = 32'h21080001; words[2] = 32'h0000000C;
    cmd(OP_LOAD_BEGIN, 32'h10);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL load_state got %0d exp 1", state); end
    for (int i = 0; i < 3; i++) begin
      cmd(OP_LOAD_WORD, words[i]);
      n_checks++; if (imem_we !== 1'b1 || imem_addr !== 8'(4 + i) || imem_wdata !== words[i]) begin n_fail++; $display("FAIL load_word%0d got we=%b a=%0d d=%h exp 1/%0d/%h", i, imem_we, imem_addr, imem_wdata, 4 + i, words[i]); end
    end
    tick();
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL load_we_pulse got %b exp 0", imem_we); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL load_core_reset got %b exp 1", core_reset); end
  endtask

  task automatic test_wrap();
    cmd(OP_LOAD_BEGIN, 32'h3FC);
    cmd(OP_LOAD_WORD, 32'hAAAA0001);
    n_checks++; if (imem_addr !== 8'd255 || imem_we !== 1'b1) begin n_fail++; $display("FAIL wrap_hi got a=%0d we=%b exp 255/1", imem_addr, imem_we); end
    cmd(OP_LOAD_WORD, 32'h55550002);
    n_checks++; if (imem_addr !== 8'd0 || imem_wdata !== 32'h55550002) begin n_fail++; $display("FAIL wrap_lo got a=%0d d=%h exp 0/55550002", imem_addr, imem_wdata); end
  endtask

  task automatic test_halt_instr();
    int en_cnt;
    cmd(OP_LOAD_BEGIN, 32'h0);
    cmd(OP_LOAD_WORD, 32'h20080005);
    cmd(OP_LOAD_WORD, 32'h21080001);
    cmd(OP_LOAD_WORD, 32'h0000000C);
    cmd(OP_RUN, 32'h0);
    n_checks++; if (state !== 3'd2 || core_reset !== 1'b0) begin n_fail++; $display("FAIL run_entry got st=%0d crst=%b exp 2/0", state, core_reset); end
    en_cnt = 0;
    for (int i = 0; i < 20 && state !== 3'd4; i++) begin
      en_cnt += int'(core_clk_en);
      tick();
    end
    n_checks++; if (en_cnt !== 2) begin n_fail++; $display("FAIL hi_en_cycles got %0d exp 2", en_cnt); end
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd2) begin n_fail++; $display("FAIL hi_halt got st=%0d cause=%0d exp 4/2", state, halt_cause); end
    n_checks++; if (cycle_count !== 32'd2) begin n_fail++; $display("FAIL hi_count got %0d exp 2", cycle_count); end
  endtask

  task automatic test_breakpoint();
    int en_cnt;
    cmd(OP_RESET_CORE, 32'h0);
    cmd(OP_LOAD_BEGIN, 32'h0);
    for (int i = 0; i < 8; i++) cmd(OP_LOAD_WORD, 32'h21080001);
    cmd(OP_SET_BP, 32'h8);
    cmd(OP_RUN, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 20 && state !== 3'd4; i++) begin
      en_cnt += int'(core_clk_en);
      tick();
    end
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd3 || core_pc !== 32'h8) begin n_fail++; $display("FAIL bp_hit got st=%0d cause=%0d pc=%h exp 4/3/8", state, halt_cause, core_pc); end
    n_checks++; if (en_cnt !== 2 || cycle_count !== 32'd2) begin n_fail++; $display("FAIL bp_count got en=%0d cnt=%0d exp 2/2", en_cnt, cycle_count); end
    cmd(OP_RUN, 32'h0);
    n_checks++; if (state !== 3'd2 || halt_cause !== 3'd0 || core_clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume got st=%0d cause=%0d en=%b exp 2/0/1", state, halt_cause, core_clk_en); end
    cmd(OP_HALT, 32'h0);
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd1 || cycle_count !== 32'd3 || core_pc !== 32'hC) begin n_fail++; $display("FAIL user_halt got st=%0d cause=%0d cnt=%0d pc=%h exp 4/1/3/c", state, halt_cause, cycle_count, core_pc); end
    cmd(OP_STEP, 32'h0);
    n_checks++; if (state !== 3'd3 || core_clk_en !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL step_state got st=%0d en=%b rdy=%b exp 3/1/0", state, core_clk_en, cmd_ready); end
    tick();
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd1 || cycle_count !== 32'd4 || core_pc !== 32'h10) begin n_fail++; $display("FAIL step_done got st=%0d cause=%0d cnt=%0d pc=%h exp 4/1/4/10", state, halt_cause, cycle_count, core_pc); end
  endtask

  task automatic test_illegal();
    cmd(OP_RUN, 32'h0);
    cmd(OP_STEP, 32'h0);
    n_checks++; if (cmd_err !== 1'b1 || state !== 3'd2) begin n_fail++; $display("FAIL step_in_run got err=%b st=%0d exp 1/2", cmd_err, state); end
    tick();
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse got %b exp 0", cmd_err); end
    cmd(OP_RUN, 32'h0);
    n_checks++; if (cmd_err !== 1'b1 || state !== 3'd2) begin n_fail++; $display("FAIL run_in_run got err=%b st=%0d exp 1/2", cmd_err, state); end
    cmd(OP_RESET_CORE, 32'h0);
    n_checks++; if (state !== 3'd0 || core_reset !== 1'b1 || cycle_count !== 32'd0 || halt_cause !== 3'd0) begin n_fail++; $display("FAIL reset_core got st=%0d crst=%b cnt=%0d cause=%0d exp 0/1/0/0", state, core_reset, cycle_count, halt_cause); end
    cmd(OP_LOAD_WORD, 32'hDEADBEEF);
    n_checks++; if (cmd_err !== 1'b1 || state !== 3'd0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL lw_in_idle got err=%b st=%0d we=%b exp 1/0/0", cmd_err, state, imem_we); end
    cmd(OP_HALT, 32'h0);
    n_checks++; if (cmd_err !== 1'b1 || state !== 3'd0) begin n_fail++; $display("FAIL halt_in_idle got err=%b st=%0d exp 1/0", cmd_err, state); end
  endtask

  task automatic test_halt_bp_same_cycle();
    cmd(OP_SET_BP, 32'h4);
    cmd(OP_RUN, 32'h0);
    tick();
    cmd(OP_HALT, 32'h0);
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd3 || cycle_count !== 32'd1) begin n_fail++; $display("FAIL halt_bp_same got st=%0d cause=%0d cnt=%0d exp 4/3/1", state, halt_cause, cycle_count); end
    cmd(OP_SET_BP, 32'hFFFFFFFF);
    cmd(OP_RESET_CORE, 32'h0);
    cmd(OP_RUN, 32'h0);
    repeat (4) tick();
    n_checks++; if (state !== 3'd2 || cycle_count !== 32'd4) begin n_fail++; $display("FAIL bp_cleared got st=%0d cnt=%0d exp 2/4", state, cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0 || core_reset !== 1'b1 || core_clk_en !== 1'b0) begin n_fail++; $display("FAIL mid_run_rst got st=%0d crst=%b en=%b exp 0/1/0", state, core_reset, core_clk_en); end
    n_checks++; if (cycle_count !== 32'd0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_run_rst_cnt got cnt=%0d rdy=%b exp 0/0", cycle_count, cmd_ready); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load();
    cmd(OP_LOAD_BEGIN, 32'h0);
    cmd(OP_LOAD_WORD, 32'h12345678);
    #1 reset = 1'b0;
    #1;
    n_checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_load_rst got we=%b a=%0d d=%h exp 0/0/0", imem_we, imem_addr, imem_wdata); end
    #1 reset = 1'b1;
    tick();
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    int en_cnt;
    cmd(OP_LOAD_BEGIN, 32'h0);
    cmd(OP_LOAD_WORD, LOOP_INSTR);
    cmd(OP_RUN, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 60 && state !== 3'd4; i++) begin
      en_cnt += int'(core_clk_en);
      tick();
    end
    n_checks++; if (en_cnt !== 16 || cycle_count !== 32'd16) begin n_fail++; $display("FAIL wdt_cycles got en=%0d cnt=%0d exp 16/16", en_cnt, cycle_count); end
    n_checks++; if (state !== 3'd4 || halt_cause !== 3'd4) begin n_fail++; $display("FAIL wdt_halt got st=%0d cause=%0d exp 4/4", state, halt_cause); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_halt_instr();
    test_breakpoint();
    test_illegal();
    test_halt_bp_same_cycle();
    test_reset_mid_run();
    test_reset_mid_load();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/debug sequencer for the single-cycle MIPS core. It holds the core in reset while a host loads instruction memory word by word. It then releases the core and gates its state updates (PC and register/memory writes) through one clock enable. It supports run, halt, single-step, one breakpoint and halt-instruction detection. Sits between the host command interface and the core top-level, which exposes PC and instruction.

Parameters:
AW, 8, instruction-memory word-address width (2^AW words)
CNT_W, 32, cycle-counter width
HALT_INSTR, 32'h0000000C, encoding that stops the core before it executes (syscall)
WDT_CYCLES, 1024, watchdog limit in RUN cycles (used only with WATCHDOG_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  3  opcode: 0 NOP, 1 LOAD_BEGIN, 2 LOAD_WORD, 3 RUN, 4 STEP, 5 HALT, 6 SET_BP, 7 RESET_CORE
cmd_data  in  32  command operand
core_pc  in  32  current core PC (byte address)
core_instr  in  32  instruction at core_pc
core_reset  out  1  active-high reset to the core
core_clk_en  out  1  core state-update enable
imem_we  out  1  instruction-memory write strobe
imem_addr  out  AW  instruction-memory word address
imem_wdata  out  32  instruction-memory write data
state  out  3  0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALT
halt_cause  out  3  0 none, 1 user, 2 halt-instr, 3 breakpoint, 4 watchdog
cycle_count  out  CNT_W  enabled core cycles
cmd_err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (reset=0, async): state=IDLE, core_reset=1, core_clk_en=0, imem_we=0, imem_addr=0, imem_wdata=0, halt_cause=0, cycle_count=0, cmd_err=0, bp_valid=0, cmd_ready=0.
- cmd_ready=1 in every state except STEP.
- All command effects register on the accepting edge.
- LOAD_BEGIN (IDLE/LOAD/HALT):
  - ptr<=cmd_data[AW+1:2]; state->LOAD; core_reset=1.
- LOAD_WORD (LOAD only):
  - Next cycle: imem_we=1 for exactly 1 cycle, imem_addr=ptr, imem_wdata=cmd_data.
  - Then ptr<=ptr+1, wrapping 2^AW-1 -> 0.
  - Back-to-back LOAD_WORDs give one write per cycle.
- RUN:
  - From IDLE/LOAD: core_reset<=0, cycle_count<=0, halt_cause<=0, state->RUN.
  - From HALT: resume without reset, count kept, halt_cause<=0, breakpoint suppressed for the first RUN cycle.
- core_clk_en (combinational) = (state==RUN && !stop) || state==STEP.
  - stop = core_instr==HALT_INSTR, or (bp_valid && core_pc==bp_addr && !bp_skip).
  - When stop=1: the instruction is not executed; state->HALT next edge; cause 2 (instr) or 3 (bp).
  - If both stop conditions hold, cause 2 wins.
- HALT (RUN only): state->HALT, cause 1. A stop in the same cycle wins, using the stop's cause.
- STEP (HALT only):
  - State STEP for exactly 1 cycle with core_clk_en=1, ignoring halt-instr and breakpoint.
  - Then back to HALT; halt_cause unchanged.
- SET_BP (any state): bp_addr<=cmd_data, bp_valid<=1. SET_BP with cmd_data=32'hFFFFFFFF clears bp_valid.
- RESET_CORE (any state): state->IDLE, core_reset=1, cycle_count<=0, halt_cause<=0; bp kept.
- Illegal commands (LOAD_WORD outside LOAD, STEP outside HALT, HALT outside RUN, RUN in RUN, LOAD_BEGIN in RUN): accepted, no state change, cmd_err=1 next cycle.
- cycle_count increments on every cycle with core_clk_en=1 and saturates at all-ones.
- Reset mid-load or mid-run: immediate return to reset values. A pending imem_we is dropped.

Optional Feature:
WATCHDOG_EN: when defined, a counter clears on entry to RUN and counts RUN cycles with core_clk_en=1. On reaching WDT_CYCLES: core_clk_en=0 that cycle, state->HALT, halt_cause=4. When undefined: no counter logic and cause 4 is never produced.

Test Plan:
- Reset, LOAD_BEGIN data=0x10, three LOAD_WORDs 0x20080005/0x21080001/0x0000000C -> imem_we pulses at word addr 4,5,6 with those data; core_reset stays 1.
- LOAD_WORD at ptr=2^AW-1, then another -> writes at 255 then 0 (AW=8).
- RUN with HALT_INSTR at 3rd word -> core_clk_en high 2 cycles; state=HALT, halt_cause=2, cycle_count=2.
- SET_BP 0x8, RUN from IDLE -> halt when core_pc=0x8, cause 3; then STEP -> one enabled cycle; then RUN -> no re-hit at 0x8, cycle_count continues.
- STEP in RUN, LOAD_WORD in IDLE -> cmd_err pulse each, state unchanged; HALT and breakpoint in the same cycle -> halt_cause=3.
- Reset asserted mid-RUN -> outputs at reset values within the same cycle; with WATCHDOG_EN, WDT_CYCLES=16 and an infinite loop -> HALT cause 4 after 16 enabled cycles.
